pointwise_conv_engine: RTL and testbench

Parametrised 1x1 (pointwise) convolution layer engine for the SqueezeNet-style fire-module pipeline: it streams one input-feature-map channel value per accepted beat and runs DSP_NO parallel multiply-accumulate lanes, one per output channel. Each lane sums CHIN products and a per-lane bias. The lane then applies round-to-nearest fixed-point rescaling, optional ReLU and signed saturation, and emits DSP_NO output values per spatial pixel. It replaces the fixed-size per-layer expand engines: channel count, lane count, output map size and fractional shift are all parameters. It adds input stalls, saturation, rounding and an explicit start/done/ack handshake with the downstream RAM writer.

---
 rtl/pointwise_conv_engine_if.sv | 41 ++++
 rtl/pointwise_conv_engine.sv | 158 +++++++++++++++
 tb/tb_pointwise_conv_engine.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pointwise_conv_engine_if.sv
// Bus bundle for pointwise_conv_engine.
//   master : upstream side (ifm stream, weight ROM data, bias, start/ack)
//   slave  : the engine
// Signals:
//   start       - one-cycle pulse that begins a layer run
//   ifm_valid   - ifm beat valid
//   ifm         - one input channel value
//   weight_addr - channel index of the next beat to accept (ROM address)
//   weights     - ROM data for weight_addr, lane i at [i*WIDTH +: WIDTH]
//   bias        - per-lane bias in the product domain, lane i at [i*2*WIDTH +: 2*WIDTH]
//   ofm         - registered per-lane results
//   ofm_valid   - one-cycle pulse per output pixel
//   done        - layer finished, waiting for ram_ack
//   ram_ack     - downstream acknowledge of done
interface pointwise_conv_engine_if #(
    parameter int WIDTH  = 16,
    parameter int DSP_NO = 64,
    parameter int CHIN   = 112,
    parameter int AW     = (CHIN > 1) ? $clog2(CHIN) : 1
);
    logic                      start;
    logic                      ifm_valid;
    logic [WIDTH-1:0]          ifm;
    logic [AW-1:0]             weight_addr;
    logic [DSP_NO*WIDTH-1:0]   weights;
    logic [DSP_NO*2*WIDTH-1:0] bias;
    logic [DSP_NO*WIDTH-1:0]   ofm;
    logic                      ofm_valid;
    logic                      done;
    logic                      ram_ack;

    modport master (
        output start, ifm_valid, ifm, weights, bias, ram_ack,
        input  weight_addr, ofm, ofm_valid, done
    );

    modport slave (
        input  start, ifm_valid, ifm, weights, bias, ram_ack,
        output weight_addr, ofm, ofm_valid, done
    );
endinterface

// File: rtl/pointwise_conv_engine.sv
// Pointwise (1x1) convolution engine. One input channel value is accepted
// per beat; DSP_NO MAC lanes each sum CHIN products plus a bias, then round
// (half up), optionally apply ReLU and saturate to WIDTH bits.
// Ports:
//   clk - clock, rising edge
//   rst - synchronous active-high reset
//   bus - pointwise_conv_engine_if slave modport (stream, ROM, results, handshake)
module pointwise_conv_engine #(
    parameter int WIDTH  = 16,
    parameter int DSP_NO = 64,
    parameter int CHIN   = 112,
    parameter int WOUT   = 8,
    parameter int FRAC   = 14,
    parameter int RELU   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    pointwise_conv_engine_if.slave  bus
);
    localparam int AW    = (CHIN > 1) ? $clog2(CHIN) : 1;
    localparam int NPIX  = WOUT * WOUT;
    localparam int PW    = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int PRODW = 2 * WIDTH;
    localparam int ACCW  = PRODW + AW;
    // One spare bit so adding the rounding constant can never wrap.
    localparam int RW    = ACCW + 1;

    localparam logic signed [RW-1:0] HALF = RW'(1) <<< (FRAC - 1);
    localparam logic signed [RW-1:0] MAXV = RW'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [RW-1:0] MINV = ~MAXV;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    chan_cnt_q;
    logic [PW-1:0]    pix_cnt_q;
    logic             accept, last_chan, last_pix;

    // Pipeline control: s1 = operands, s2 = accumulator, s3 = rounded sum,
    // ofm = saturated output. The final flag marks the last pixel's result.
    logic             s1_valid_q, s1_first_q, s1_last_q, s1_final_q;
    logic             s2_last_q, s2_final_q;
    logic             s3_valid_q, s3_final_q;
    logic             ofm_valid_q, ofm_final_q;
    logic signed [WIDTH-1:0]  s1_ifm_q;
    logic [DSP_NO*WIDTH-1:0]  s1_w_q;
    wire  [DSP_NO*WIDTH-1:0]  ofm_flat;

    assign accept    = (state_q == S_RUN) && bus.ifm_valid;
    assign last_chan = (chan_cnt_q == AW'(CHIN - 1));
    assign last_pix  = (pix_cnt_q == PW'(NPIX - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (accept && last_chan && last_pix) state_d = S_DRAIN;
            S_DRAIN: if (ofm_valid_q && ofm_final_q) state_d = S_DONE;
            S_DONE:  if (bus.ram_ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            chan_cnt_q  <= '0;
            pix_cnt_q   <= '0;
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_final_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_final_q  <= 1'b0;
            s3_valid_q  <= 1'b0;
            s3_final_q  <= 1'b0;
            ofm_valid_q <= 1'b0;
            ofm_final_q <= 1'b0;
            s1_ifm_q    <= '0;
            s1_w_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                chan_cnt_q <= last_chan ? '0 : chan_cnt_q + 1'b1;
                if (last_chan) begin
                    pix_cnt_q <= last_pix ? '0 : pix_cnt_q + 1'b1;
                end
                s1_ifm_q <= bus.ifm;
                s1_w_q   <= bus.weights;
            end
            s1_valid_q  <= accept;
            s1_first_q  <= (chan_cnt_q == '0);
            s1_last_q   <= last_chan;
            s1_final_q  <= last_chan && last_pix;
            s2_last_q   <= s1_valid_q && s1_last_q;
            s2_final_q  <= s1_valid_q && s1_final_q;
            s3_valid_q  <= s2_last_q;
            s3_final_q  <= s2_final_q;
            ofm_valid_q <= s3_valid_q;
            ofm_final_q <= s3_final_q;
        end
    end

    for (genvar gi = 0; gi < DSP_NO; gi++) begin : g_lane
        logic signed [WIDTH-1:0] w_lane;
        logic signed [PRODW-1:0] bias_lane;
        logic signed [PRODW-1:0] prod;
        logic signed [ACCW-1:0]  acc_q;
        logic signed [RW-1:0]    rnd_sum;
        logic signed [RW-1:0]    r_q;
        logic signed [WIDTH-1:0] sat;
        logic        [WIDTH-1:0] ofm_lane_q;

        assign w_lane    = s1_w_q[gi*WIDTH +: WIDTH];
        assign bias_lane = bus.bias[gi*PRODW +: PRODW];
        assign prod      = PRODW'(s1_ifm_q) * PRODW'(w_lane);
        assign rnd_sum   = RW'(acc_q) + HALF;

        // ReLU takes priority; otherwise clamp to the signed WIDTH range.
        always_comb begin
            sat = r_q[WIDTH-1:0];
            if ((RELU != 0) && r_q[RW-1]) begin
                sat = '0;
            end else if (r_q > MAXV) begin
                sat = MAXV[WIDTH-1:0];
            end else if (r_q < MINV) begin
                sat = MINV[WIDTH-1:0];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                acc_q      <= '0;
                r_q        <= '0;
                ofm_lane_q <= '0;
            end else begin
                // The first channel reloads, so stale sums never leak into a new pixel.
                if (s1_valid_q) begin
                    acc_q <= s1_first_q ? ACCW'(prod) + ACCW'(bias_lane)
                                        : acc_q + ACCW'(prod);
                end
                if (s2_last_q) begin
                    r_q <= rnd_sum >>> FRAC;
                end
                if (s3_valid_q) begin
                    ofm_lane_q <= sat;
                end
            end
        end

        assign ofm_flat[gi*WIDTH +: WIDTH] = ofm_lane_q;
    end

    assign bus.weight_addr = chan_cnt_q;
    assign bus.ofm         = ofm_flat;
    assign bus.ofm_valid   = ofm_valid_q;
    assign bus.done        = (state_q == S_DONE);
endmodule

// File: tb/tb_pointwise_conv_engine.sv
module tb_pointwise_conv_engine;
    localparam int WIDTH  = 16;
    localparam int DSP_NO = 2;
    localparam int CHIN   = 4;
    localparam int WOUT   = 2;
    localparam int FRAC   = 14;
    localparam int NPIX   = WOUT * WOUT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pointwise_conv_engine_if #(.WIDTH(WIDTH), .DSP_NO(DSP_NO), .CHIN(CHIN)) bus_a ();
    pointwise_conv_engine_if #(.WIDTH(WIDTH), .DSP_NO(DSP_NO), .CHIN(CHIN)) bus_b ();

    pointwise_conv_engine #(.WIDTH(WIDTH), .DSP_NO(DSP_NO), .CHIN(CHIN), .WOUT(WOUT),
                            .FRAC(FRAC), .RELU(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    pointwise_conv_engine #(.WIDTH(WIDTH), .DSP_NO(DSP_NO), .CHIN(CHIN), .WOUT(WOUT),
                            .FRAC(FRAC), .RELU(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    logic             start_s = 1'b0;
    logic             valid_s = 1'b0;
    logic             ack_s   = 1'b0;
    logic [WIDTH-1:0] ifm_s   = '0;

    int     img[NPIX][CHIN];
    int     rom[CHIN][DSP_NO];
    longint bias_v[DSP_NO];

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int exp_cyc_q[$];
    int exp_val_q[$];
    int hold_a[DSP_NO];
    int hold_b[DSP_NO];
    int last_exp_cyc = 0;
    bit expv;

    always @(posedge clk) cyc <= cyc + 1;

    // Weight ROM and static inputs feed both engines.
    always_comb begin
        bus_a.start = start_s;  bus_b.start = start_s;
        bus_a.ifm_valid = valid_s;  bus_b.ifm_valid = valid_s;
        bus_a.ifm = ifm_s;  bus_b.ifm = ifm_s;
        bus_a.ram_ack = ack_s;  bus_b.ram_ack = ack_s;
        bus_a.weights = '0;  bus_b.weights = '0;
        bus_a.bias = '0;  bus_b.bias = '0;
        for (int l = 0; l < DSP_NO; l++) begin
            bus_a.weights[l*WIDTH +: WIDTH] = WIDTH'(rom[bus_a.weight_addr][l]);
            bus_b.weights[l*WIDTH +: WIDTH] = WIDTH'(rom[bus_b.weight_addr][l]);
            bus_a.bias[l*2*WIDTH +: 2*WIDTH] = bias_v[l][2*WIDTH-1:0];
            bus_b.bias[l*2*WIDTH +: 2*WIDTH] = bias_v[l][2*WIDTH-1:0];
        end
    end

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: dot product plus bias, floor((sum + half) / 2^FRAC), ReLU, clamp.
    function automatic int model(input int p, input int l, input bit relu);
        longint s;
        longint r;
        s = bias_v[l];
        for (int c = 0; c < CHIN; c++) s += longint'(img[p][c]) * longint'(rom[c][l]);
        r = (s + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
        if (relu && r < 0) r = 0;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    // Output monitor: ofm_valid must appear exactly on the predicted cycle,
    // and ofm must show the most recent expected result at all times.
    always @(negedge clk) begin
        if (!rst) begin
            expv = (exp_cyc_q.size() != 0) && (exp_cyc_q[0] == cyc);
            check_val("ofm_valid_a", longint'(bus_a.ofm_valid), longint'(expv));
            check_val("ofm_valid_b", longint'(bus_b.ofm_valid), longint'(expv));
            if (exp_cyc_q.size() != 0 && exp_cyc_q[0] <= cyc) begin
                void'(exp_cyc_q.pop_front());
                for (int l = 0; l < DSP_NO; l++) hold_a[l] = exp_val_q.pop_front();
                for (int l = 0; l < DSP_NO; l++) hold_b[l] = exp_val_q.pop_front();
                $display("pixel out cyc=%0d relu1=(%0d,%0d) relu0=(%0d,%0d)",
                         cyc, hold_a[0], hold_a[1], hold_b[0], hold_b[1]);
            end
            for (int l = 0; l < DSP_NO; l++) begin
                check_val("ofm_a", longint'($signed(bus_a.ofm[l*WIDTH +: WIDTH])), longint'(hold_a[l]));
                check_val("ofm_b", longint'($signed(bus_b.ofm[l*WIDTH +: WIDTH])), longint'(hold_b[l]));
            end
        end
    end

    task automatic fill_const(input int x, input int w, input longint b);
        for (int p = 0; p < NPIX; p++) for (int c = 0; c < CHIN; c++) img[p][c] = x;
        for (int c = 0; c < CHIN; c++) for (int l = 0; l < DSP_NO; l++) rom[c][l] = w;
        for (int l = 0; l < DSP_NO; l++) bias_v[l] = b;
    endtask

    task automatic fill_rand();
        int mag;
        mag = ($urandom_range(0, 1) == 0) ? 4096 : 32768;
        for (int p = 0; p < NPIX; p++)
            for (int c = 0; c < CHIN; c++) img[p][c] = int'($urandom_range(0, 2*mag - 1)) - mag;
        for (int c = 0; c < CHIN; c++)
            for (int l = 0; l < DSP_NO; l++) rom[c][l] = int'($urandom_range(0, 2*mag - 1)) - mag;
        for (int l = 0; l < DSP_NO; l++) bias_v[l] = longint'($signed($urandom));
    endtask

    // stall_mode: 0 none, 1 three idle cycles before channel 2, 2 random gaps.
    // abort_at >= 0 stops before that beat index (used for the mid-run reset).
    task automatic run_layer(input int stall_mode, input int abort_at);
        int beats;
        int ea;
        int gap;
        int k;
        beats = 0;
        ea = 0;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        for (int p = 0; p < NPIX; p++) begin
            for (int c = 0; c < CHIN; c++) begin
                gap = 0;
                if (stall_mode == 1 && c == 2) gap = 3;
                if (stall_mode == 2 && $urandom_range(0, 3) == 0) gap = int'($urandom_range(1, 3));
                for (int g = 0; g < gap; g++) begin
                    valid_s = 1'b0;
                    ifm_s = WIDTH'($urandom);
                    if (stall_mode == 2) ack_s = 1'($urandom_range(0, 1));
                    check_val("addr_stall", longint'(bus_a.weight_addr), longint'(c));
                    @(negedge clk);
                end
                ack_s = 1'b0;
                if (abort_at >= 0 && beats == abort_at) begin
                    valid_s = 1'b0;
                    return;
                end
                check_val("addr_a", longint'(bus_a.weight_addr), longint'(c));
                check_val("addr_b", longint'(bus_b.weight_addr), longint'(c));
                valid_s = 1'b1;
                ifm_s = img[p][c][WIDTH-1:0];
                @(negedge clk);
                ea = cyc;
                beats++;
            end
            exp_cyc_q.push_back(ea + 3);
            for (int l = 0; l < DSP_NO; l++) exp_val_q.push_back(model(p, l, 1'b1));
            for (int l = 0; l < DSP_NO; l++) exp_val_q.push_back(model(p, l, 1'b0));
            last_exp_cyc = ea + 3;
        end
        valid_s = 1'b0;
        k = 0;
        while (!bus_a.done && k < 40) begin
            @(negedge clk);
            k++;
        end
        check_val("done_cycle", longint'(cyc), longint'(last_exp_cyc + 1));
        check_val("done_b", longint'(bus_b.done), 1);
        check_val("pending_results", longint'(exp_cyc_q.size()), 0);
    endtask

    task automatic ack_done(input int hold, input bit poke_start);
        for (int i = 0; i < hold; i++) begin
            check_val("done_hold", longint'(bus_a.done), 1);
            start_s = (poke_start && i == 4);
            ack_s = 1'b0;
            @(negedge clk);
        end
        start_s = 1'b0;
        ack_s = 1'b1;
        @(negedge clk);
        ack_s = 1'b0;
        check_val("done_clear_a", longint'(bus_a.done), 0);
        check_val("done_clear_b", longint'(bus_b.done), 0);
        check_val("addr_idle", longint'(bus_a.weight_addr), 0);
    endtask

    task automatic check_reset_outputs();
        for (int l = 0; l < DSP_NO; l++) begin
            check_val("rst_ofm_a", longint'(bus_a.ofm[l*WIDTH +: WIDTH]), 0);
            check_val("rst_ofm_b", longint'(bus_b.ofm[l*WIDTH +: WIDTH]), 0);
        end
        check_val("rst_valid", longint'(bus_a.ofm_valid), 0);
        check_val("rst_done", longint'(bus_a.done), 0);
        check_val("rst_addr", longint'(bus_a.weight_addr), 0);
    endtask

    initial begin
        fill_const(0, 0, 0);
        for (int l = 0; l < DSP_NO; l++) begin
            hold_a[l] = 0;
            hold_b[l] = 0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        @(negedge clk);

        fill_const(8192, 8192, 0);            run_layer(0, -1); ack_done(0, 0);
        fill_const(16384, 16384, 0);          run_layer(0, -1); ack_done(0, 0);
        fill_const(8192, 8192, 134217728);    run_layer(0, -1); ack_done(0, 0);
        fill_const(8192, -8192, 0);           run_layer(0, -1); ack_done(0, 0);
        fill_const(16384, -16384, 0);         run_layer(0, -1); ack_done(0, 0);
        fill_const(8192, 8192, 0);            run_layer(1, -1); ack_done(10, 1);

        // Rounding boundary: sum of products is exactly 2^14.
        fill_const(8192, 8192, 0);
        for (int p = 0; p < NPIX; p++) begin
            img[p][0] = 1; img[p][1] = 1; img[p][2] = 0; img[p][3] = 0;
        end
        run_layer(0, -1); ack_done(0, 0);
        bias_v[0] = -1;
        bias_v[1] = -8193;
        run_layer(0, -1); ack_done(0, 0);

        // Reset after channel 2 of pixel 1, then a clean rerun.
        fill_const(8192, 8192, 0);
        run_layer(0, 7);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        exp_cyc_q.delete();
        exp_val_q.delete();
        for (int l = 0; l < DSP_NO; l++) begin
            hold_a[l] = 0;
            hold_b[l] = 0;
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_layer(0, -1); ack_done(0, 0);

        for (int r = 0; r < 8; r++) begin
            fill_rand();
            run_layer(2, -1);
            ack_done(int'($urandom_range(0, 3)), 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
